// File: rtl/rem3_pkg.sv
// Shared types and the mod-3 step function used by the serial transmitter
// and by any receiver-side checker.
package rem3_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Appending bit b to a value with remainder r gives remainder (2r + b) mod 3.
  function automatic logic [1:0] rem3_next(input logic [1:0] r, input logic b);
    logic [1:0] res;
    case ({r, b})
      3'b000:  res = 2'd0;
      3'b001:  res = 2'd1;
      3'b010:  res = 2'd2;
      3'b011:  res = 2'd0;
      3'b100:  res = 2'd1;
      3'b101:  res = 2'd2;
      default: res = 2'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mod3_acc.sv
// Running remainder-mod-3 accumulator: clears on a new word, otherwise folds
// in one bit per enabled cycle. r_next is the remainder including bit b.
module mod3_acc
  import rem3_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       b,
  output logic [1:0] r,
  output logic [1:0] r_next
);

  logic [1:0] r_q;
  logic [1:0] r_d;

  assign r_next = rem3_next(r_q, b);
  assign r      = r_q;

  // Clear takes priority so a back-to-back word starts from zero.
  always_comb begin
    r_d = r_q;
    if (clr) begin
      r_d = 2'd0;
    end else if (en) begin
      r_d = r_next;
    end else begin
      r_d = r_q;
    end
  end

  // Remainder register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= 2'd0;
    end else begin
      r_q <= r_d;
    end
  end

endmodule

// File: rtl/rem3_serial_tx.sv
// Serial transmitter for the remainder-mod-3 link: accepts a word, shifts it
// out MSB first and reports the remainder of the word when it completes.
module rem3_serial_tx
  import rem3_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             x_valid,
  output logic             x_first,
  output logic             x_last,
  output logic [1:0]       exp_rem,
  output logic             done,
  output logic [1:0]       done_rem
);

  localparam logic [4:0] CNT_MAX = 5'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic [1:0]       done_rem_q, done_rem_d;
  logic [1:0]       r_s;
  logic [1:0]       r_next_s;
  logic             accept_s;

  // The LSB cycle also accepts, which lets words run back to back.
  assign in_ready = (state_q == IDLE) || last_q;
  assign accept_s = in_valid && in_ready;

  mod3_acc u_acc (
    .clk    (clk),
    .reset  (reset),
    .clr    (accept_s),
    .en     (valid_q),
    .b      (shreg_q[WIDTH-1]),
    .r      (r_s),
    .r_next (r_next_s)
  );

  // Next-state: load on accept, shift while bits remain, otherwise idle with
  // the shift register cleared so the serial line rests at zero.
  always_comb begin
    state_d    = IDLE;
    shreg_d    = {WIDTH{1'b0}};
    cnt_d      = cnt_q;
    valid_d    = 1'b0;
    first_d    = 1'b0;
    last_d     = 1'b0;
    done_d     = last_q;
    done_rem_d = done_rem_q;
    if (last_q) begin
      done_rem_d = r_next_s;
    end else begin
      done_rem_d = done_rem_q;
    end
    if (accept_s) begin
      state_d = SHIFT;
      shreg_d = in_data;
      cnt_d   = CNT_MAX;
      valid_d = 1'b1;
      first_d = 1'b1;
      last_d  = (CNT_MAX == 5'd0);
    end else if ((state_q == SHIFT) && !last_q) begin
      state_d = SHIFT;
      shreg_d = shreg_q << 1;
      cnt_d   = cnt_q - 5'd1;
      valid_d = 1'b1;
      first_d = 1'b0;
      last_d  = (cnt_q == 5'd1);
    end else begin
      state_d = IDLE;
      shreg_d = {WIDTH{1'b0}};
      cnt_d   = cnt_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      shreg_q    <= {WIDTH{1'b0}};
      cnt_q      <= 5'd0;
      valid_q    <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      done_rem_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      first_q    <= first_d;
      last_q     <= last_d;
      done_q     <= done_d;
      done_rem_q <= done_rem_d;
    end
  end

  assign x        = shreg_q[WIDTH-1];
  assign x_valid  = valid_q;
  assign x_first  = first_q;
  assign x_last   = last_q;
  assign exp_rem  = r_s;
  assign done     = done_q;
  assign done_rem = done_rem_q;

endmodule

// File: doc/rem3_serial_tx.md
# rem3_serial_tx

Transmit end of the serial remainder-mod-3 link. Accepts a parallel word over a valid/ready handshake and shifts it out MSB-first, one bit per clock, on the `x` line consumed by the `rem3` remainder FSM. It also tracks the running remainder mod 3 of the transmitted prefix, so the bench and downstream checkers have a golden reference. At each word end it reports the final remainder.

## Interface
- `WIDTH`, default 8: bits per word, legal range 1..32.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_data`  in  WIDTH  word to transmit, sampled on accept.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a word this cycle.
- `x`  out  1  serial bit, MSB first (drives `rem3.x`).
- `x_valid`  out  1  `x` carries a word bit this cycle.
- `x_first`  out  1  current bit is the word MSB.
- `x_last`  out  1  current bit is the word LSB.
- `exp_rem`  out  2  remainder mod 3 of all bits of the current word already shifted out, excluding the current bit.
- `done`  out  1  one-cycle pulse, the cycle after the LSB.
- `done_rem`  out  2  final remainder of the last completed word. Holds until the next `done`.

## Operation
- States are IDLE and SHIFT.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, load the shift register with `in_data`, bit counter with WIDTH-1, and `r` with 0, then go to SHIFT.
- SHIFT:
  - `x_valid`=1 and `x`=shift-register MSB.
  - `x_first`=1 when the counter equals WIDTH-1; `x_last`=1 when the counter equals 0.
  - Each cycle, shift left, decrement the counter, and update r ← (2r + x) mod 3.
  - r takes values 0..2 only; the value 3 is never produced.
- Last bit (`x_last`=1):
  - `in_ready`=1 in that cycle, which allows back-to-back words.
  - If accepted, reload and stay in SHIFT. The next cycle then shows the new MSB with `x_first`=1, with no bubble.
  - If not accepted, go to IDLE.
- Done reporting: the cycle after any `x_last` has `done`=1 and `done_rem`=(2r+x) mod 3 of that LSB. This holds even if a new word started in that cycle.
- `exp_rem` = r. It resets to 0 at each word accept, so `exp_rem`=0 whenever `x_first`=1.
- In IDLE, `x`=0, `x_valid`=0, `x_first`=0, `x_last`=0, and `exp_rem` holds its last value.
- `in_data` is ignored except on an accept cycle. `in_valid` with `in_ready`=0 is ignored.
- WIDTH=1: every SHIFT cycle has both `x_first` and `x_last` set.

## Timing
- Reset values (asynchronous, while `reset`=0):
  - state IDLE;
  - `in_ready`=1;
  - `x`=0, `x_valid`=0, `x_first`=0, `x_last`=0;
  - `exp_rem`=0;
  - `done`=0, `done_rem`=0.
- Reset mid-word: the word is abandoned, no `done` is produced, and the block returns to the reset values above.
- Latency from accept edge T:
  - MSB on `x` in cycle T+1;
  - LSB in cycle T+WIDTH;
  - `done` in cycle T+WIDTH+1.
- Throughput: one word per WIDTH cycles under back-to-back traffic.
- All outputs are registered except `in_ready`, which decodes combinationally from state and `x_last`.
- `done_rem` equals the value the `rem3` receiver shows on `out` after clocking the same bits.

## Structure
- Package `rem3_pkg`:
  - state enum {IDLE, SHIFT};
  - function `rem3_next(r[1:0], b)` returning (2r+b) mod 3, shared with the receiver checker.
- Sub-module `mod3_acc`: holds r, with `clr` and `en` inputs and a `b` input; outputs `r` and `r_next`. Instantiated once.
- Top-level block: handshake, shift register, counter, state.

## Test plan
- WIDTH=8, `in_data`=0xB3 (10110011):
  - `x` sequence 1,0,1,1,0,0,1,1;
  - `exp_rem` 0,1,2,2,2,1,2,2;
  - `done`=1 with `done_rem`=2 at T+9.
- WIDTH=9, `in_data`=0x166 (101100110): `done_rem`=1.
- 0x00 → `done_rem`=0, and 0xFF → `done_rem`=0.
- Back-to-back 0xB3 then 0x01 with `in_valid` held:
  - `x_first` in the cycle after `x_last`, with no gap;
  - `done_rem`=2 then 1.
- Reset pulsed at bit 4 of 0xB3:
  - all outputs go to reset values immediately, and no `done` is produced;
  - the next word 0x03 gives `done_rem`=0.
- WIDTH=1:
  - bit 1 → `done_rem`=1 with `x_first` and `x_last` both set;
  - continuous `in_valid` → one word per cycle.
